// File: rtl/dmem_sized_pkg.sv
// Shared definitions for the MEM-stage data memory:
// load/store size encodings and size/extension helpers.
package riscv_mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_D  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
    localparam logic [2:0] SZ_WU = 3'b110;

    typedef enum logic {
        ST_IDLE,
        ST_SPLIT
    } dmem_state_e;

    function automatic logic [3:0] size_to_nbytes(
        input logic [2:0] sz
    );
        logic [3:0] n;
        unique case (sz[1:0])
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Size[2] selects zero extension; 111 behaves as a full doubleword.
    function automatic logic [63:0] extend_load(
        input logic [63:0] raw,
        input logic [2:0]  sz
    );
        logic [63:0] r;
        unique case (sz[1:0])
            2'b00: r = sz[2] ? {56'h0, raw[7:0]}
                             : {{56{raw[7]}}, raw[7:0]};
            2'b01: r = sz[2] ? {48'h0, raw[15:0]}
                             : {{48{raw[15]}}, raw[15:0]};
            2'b10: r = sz[2] ? {32'h0, raw[31:0]}
                             : {{32{raw[31]}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_sized_if.sv
// MEM-stage data memory bus: pipeline request side and
// memory response side.
interface dmem_sized_if #(
    parameter int XLEN = 64
);

    logic [XLEN-1:0] Mem_Addr;
    logic [XLEN-1:0] Write_Data;
    logic            MemRead;
    logic            MemWrite;
    logic [2:0]      Size;
    logic [XLEN-1:0] Read_Data;
    logic            Read_Valid;
    logic            Stall;
    logic            Addr_Fault;

    modport master (
        output Mem_Addr,
        output Write_Data,
        output MemRead,
        output MemWrite,
        output Size,
        input  Read_Data,
        input  Read_Valid,
        input  Stall,
        input  Addr_Fault
    );

    modport slave (
        input  Mem_Addr,
        input  Write_Data,
        input  MemRead,
        input  MemWrite,
        input  Size,
        output Read_Data,
        output Read_Valid,
        output Stall,
        output Addr_Fault
    );

endinterface

// File: rtl/dmem_sized_bank.sv
// 64-bit word array with byte-enable write and two
// combinational word read ports.
module dmem_bank #(
    parameter int DEPTH_BYTES  = 64,
    parameter int INIT_PATTERN = 1,
    parameter int AW           = $clog2(DEPTH_BYTES / 8)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] w_idx,
    input  logic [7:0]    w_be,
    input  logic [63:0]   w_data,
    input  logic [AW-1:0] r_idx0,
    input  logic [AW-1:0] r_idx1,
    output logic [63:0]   r_data0,
    output logic [63:0]   r_data1
);

    localparam int WORDS = DEPTH_BYTES / 8;

    logic [63:0] words [WORDS];

    function automatic logic [63:0] init_word(input int w);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < 8; b++) begin
            v[8*b +: 8] = (INIT_PATTERN != 0) ? 8'(w * 8 + b)
                                              : 8'h00;
        end
        return v;
    endfunction

    // Contents come only from the power-up image; reset never clears them.
    for (genvar w = 0; w < WORDS; w++) begin : g_word
        logic [63:0] word_q = init_word(w);

        always_ff @(posedge clk) begin
            if (we && w_idx == AW'(w)) begin
                for (int b = 0; b < 8; b++) begin
                    if (w_be[b]) begin
                        word_q[8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
        end

        assign words[w] = word_q;
    end

    assign r_data0 = words[r_idx0];
    assign r_data1 = words[r_idx1];

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressed MEM-stage data memory with sized loads/stores,
// two-beat split for word-crossing accesses and range faulting.
import riscv_mem_pkg::*;

module dmem_sized #(
    parameter int DEPTH_BYTES  = 64,
    parameter int XLEN         = 64,
    parameter int INIT_PATTERN = 1
) (
    input logic         clk,
    input logic         reset,
    dmem_sized_if.slave bus
);

    localparam int WORDS = DEPTH_BYTES / 8;
    localparam int AW    = $clog2(WORDS);

    dmem_state_e state_q, state_d;

    logic [2:0]    lane_q;
    logic [2:0]    size_q;
    logic [63:0]   data_q;
    logic [63:0]   lo_q;
    logic [AW-1:0] idx_q;
    logic          store_q;

    logic [63:0] rd_q, rd_d;
    logic        rv_q, rv_d;
    logic        af_q, af_d;

    logic          req;
    logic [3:0]    nbytes;
    logic [2:0]    lane;
    logic [AW-1:0] idx;
    logic [XLEN:0] end_addr;
    logic          fault;
    logic          split;
    logic          in_split;

    logic [2:0]   sel_lane;
    logic [2:0]   sel_size;
    logic [63:0]  sel_data;
    logic [15:0]  be_mask;
    logic [15:0]  wide_be;
    logic [127:0] wide_data;

    logic [AW-1:0] rd_idx0, rd_idx1;
    logic [63:0]   r_data0, r_data1;
    logic [127:0]  rd_pair;
    logic [63:0]   raw;

    logic          we;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_be;
    logic [63:0]   w_data;
    logic          stall;
    logic          latch;

    assign req      = bus.MemRead | bus.MemWrite;
    assign nbytes   = size_to_nbytes(bus.Size);
    assign lane     = bus.Mem_Addr[2:0];
    assign idx      = bus.Mem_Addr[AW+2:3];
    assign in_split = (state_q == ST_SPLIT);

    // Extra top bit keeps the range check from wrapping near 2^64.
    assign end_addr = {1'b0, bus.Mem_Addr} + (XLEN+1)'(nbytes);
    assign fault    = end_addr > (XLEN+1)'(DEPTH_BYTES);
    assign split    = ({1'b0, lane} + nbytes) > 4'd8;

    assign sel_lane = in_split ? lane_q : lane;
    assign sel_size = in_split ? size_q : bus.Size;
    assign sel_data = in_split ? data_q : bus.Write_Data;

    // Low half of the wide vectors targets word idx, high half idx+1.
    assign be_mask   = (16'h1 << size_to_nbytes(sel_size)) - 16'h1;
    assign wide_be   = {8'h00, be_mask[7:0]} << sel_lane;
    assign wide_data = {64'h0, sel_data} << {sel_lane, 3'b000};

    assign rd_idx0 = in_split ? idx_q : idx;
    assign rd_idx1 = rd_idx0 + AW'(1);
    assign rd_pair = {r_data1, in_split ? lo_q : r_data0};
    assign raw     = 64'(rd_pair >> {sel_lane, 3'b000});

    dmem_bank #(
        .DEPTH_BYTES  (DEPTH_BYTES),
        .INIT_PATTERN (INIT_PATTERN),
        .AW           (AW)
    ) u_bank (
        .clk     (clk),
        .we      (we),
        .w_idx   (w_idx),
        .w_be    (w_be),
        .w_data  (w_data),
        .r_idx0  (rd_idx0),
        .r_idx1  (rd_idx1),
        .r_data0 (r_data0),
        .r_data1 (r_data1)
    );

    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        w_idx   = idx;
        w_be    = wide_be[7:0];
        w_data  = wide_data[63:0];
        stall   = 1'b0;
        latch   = 1'b0;
        rd_d    = rd_q;
        rv_d    = 1'b0;
        af_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (fault) begin
                        af_d = 1'b1;
                        rv_d = 1'b1;
                        rd_d = '0;
                    end else if (split) begin
                        stall   = 1'b1;
                        latch   = 1'b1;
                        we      = bus.MemWrite;
                        state_d = ST_SPLIT;
                    end else if (bus.MemWrite) begin
                        we = 1'b1;
                    end else begin
                        rv_d = 1'b1;
                        rd_d = extend_load(raw, bus.Size);
                    end
                end
            end
            ST_SPLIT: begin
                state_d = ST_IDLE;
                w_idx   = idx_q + AW'(1);
                w_be    = wide_be[15:8];
                w_data  = wide_data[127:64];
                if (store_q) begin
                    we = 1'b1;
                end else begin
                    rv_d = 1'b1;
                    rd_d = extend_load(raw, size_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset aborts a pending second beat; the first beat stays.
        if (reset) begin
            we    = 1'b0;
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            rv_q    <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            rv_q    <= rv_d;
            af_q    <= af_d;
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            lane_q  <= lane;
            size_q  <= bus.Size;
            data_q  <= bus.Write_Data;
            idx_q   <= idx;
            store_q <= bus.MemWrite;
            lo_q    <= r_data0;
        end
    end

    assign bus.Read_Data  = rd_q;
    assign bus.Read_Valid = rv_q;
    assign bus.Stall      = stall;
    assign bus.Addr_Fault = af_q;

endmodule
